// File: rtl/mt_maint_pkg.sv
// Shared types and field positions for the MT maintenance-mode sequencer.
package mt_maint_pkg;

  // Bit positions of the fields inside the maintenance register word.
  localparam int unsigned MR_MM      = 0;
  localparam int unsigned MR_MOP_LSB = 1;
  localparam int unsigned MR_MOP_MSB = 4;
  localparam int unsigned MR_MC      = 5;
  localparam int unsigned MR_BPICLK  = 6;
  localparam int unsigned MR_MDF_LSB = 7;
  localparam int unsigned MR_MDF_MSB = 15;

  typedef logic [8:0] mtChar_t;

  typedef enum logic [3:0] {
    MOP_NONE   = 4'd0,
    MOP_SINGLE = 4'd1,
    MOP_REPEAT = 4'd2,
    MOP_COUNT  = 4'd3,
    MOP_WALK   = 4'd4
  } mop_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_SEND,
    ST_DONE
  } state_e;

  // Only operations 1..4 start a record; the rest behave as "none".
  function automatic logic mopActive(input logic [3:0] m);
    return (m >= 4'd1) && (m <= 4'd4);
  endfunction

endpackage

// File: rtl/mt_maint_pat.sv
// Pattern generator: holds the next character of the current record.
module mt_maint_pat
  import mt_maint_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    load,
  input  logic    advance,
  input  mop_e    mode,
  input  mtChar_t seed,
  output mtChar_t curChar
);

  mop_e modeQ;

  // Load the first character on record start, step it after each transfer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      modeQ   <= MOP_NONE;
      curChar <= '0;
    end else if (load) begin
      modeQ   <= mode;
      curChar <= (mode == MOP_WALK) ? 9'h001 : seed;
    end else if (advance) begin
      case (modeQ)
        MOP_COUNT: curChar <= curChar + 9'd1;
        MOP_WALK:  curChar <= {curChar[7:0], curChar[8]};
        default:   curChar <= curChar;
      endcase
    end
  end

endmodule

// File: rtl/mt_maint_seq.sv
// Maintenance-mode character sequencer: decodes the live MR word and emits
// BPI-paced read characters through a valid/ready handshake.
module mt_maint_seq
  import mt_maint_pkg::*;
#(
  parameter int unsigned RECLEN = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] mtMR,
  input  logic        mtmrWRITE,
  output logic [8:0]  mtMDATA,
  output logic        mtMVALID,
  input  logic        mtMREADY,
  output logic        mtMEOR,
  output logic        mtMBUSY,
  output logic        mtMOVR
);

  localparam logic [11:0] RECLEN_W = 12'(RECLEN);

  state_e      state;
  state_e      stateNxt;
  logic        bpiPrev;
  logic        bpiRise;
  logic        mm;
  mop_e        mopIn;
  mtChar_t     mdfIn;
  mtChar_t     patChar;
  logic        start;
  logic        xfer;
  logic        loadChar;
  logic [11:0] count;
  logic        unusedMc;

  assign mm       = mtMR[MR_MM];
  assign mopIn    = mop_e'(mtMR[MR_MOP_MSB:MR_MOP_LSB]);
  assign mdfIn    = mtMR[MR_MDF_MSB:MR_MDF_LSB];
  assign unusedMc = mtMR[MR_MC];
  assign bpiRise  = mtMR[MR_BPICLK] & ~bpiPrev;

  assign start    = (state == ST_IDLE) && mm && mopActive(mtMR[MR_MOP_MSB:MR_MOP_LSB]) && !mtmrWRITE;
  assign xfer     = (state == ST_SEND) && mtMREADY;
  assign loadChar = (state == ST_WAIT) && mm && bpiRise && !mtmrWRITE;

  assign mtMVALID = (state == ST_SEND);
  assign mtMBUSY  = (state != ST_IDLE);

  // BPI clock sample for rising-edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) bpiPrev <= 1'b0;
    else      bpiPrev <= mtMR[MR_BPICLK];
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= stateNxt;
  end

  // Next-state decode; an MR write overrides everything.
  always_comb begin
    stateNxt = state;
    if (mtmrWRITE) begin
      stateNxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (start) stateNxt = ST_WAIT;
        ST_WAIT: begin
          if (!mm)          stateNxt = ST_IDLE;
          else if (bpiRise) stateNxt = ST_SEND;
        end
        ST_SEND: begin
          if (!mm)           stateNxt = ST_IDLE;
          else if (mtMREADY) stateNxt = mtMEOR ? ST_DONE : ST_WAIT;
        end
        ST_DONE: if (!mm) stateNxt = ST_IDLE;
        default: stateNxt = ST_IDLE;
      endcase
    end
  end

  // Remaining-character count and the registered output character.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count   <= '0;
      mtMDATA <= '0;
      mtMEOR  <= 1'b0;
    end else if (mtmrWRITE) begin
      count <= '0;
    end else begin
      if (start)
        count <= (mopIn == MOP_SINGLE) ? 12'd1 : RECLEN_W;
      else if (xfer)
        count <= count - 12'd1;
      if (loadChar) begin
        mtMDATA <= patChar;
        mtMEOR  <= (count == 12'd1);
      end
    end
  end

  // Sticky overrun: BPI edge while a character is still unaccepted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      mtMOVR <= 1'b0;
    else if (mtmrWRITE)
      mtMOVR <= 1'b0;
    else if ((state == ST_SEND) && bpiRise && !mtMREADY)
      mtMOVR <= 1'b1;
  end

  mt_maint_pat u_pat (
    .clk     (clk),
    .rst     (rst),
    .load    (start),
    .advance (xfer),
    .mode    (mopIn),
    .seed    (mdfIn),
    .curChar (patChar)
  );

endmodule

// File: tb/tb_mt_maint_seq.sv
// Bench for mt_maint_seq: record-level reference model plus directed cases.
module tb_mt_maint_seq;

  localparam int unsigned RECLEN = 10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] mtMR = '0;
  logic        mtmrWRITE = 1'b0;
  logic        mtMREADY = 1'b0;
  logic [8:0]  mtMDATA;
  logic        mtMVALID;
  logic        mtMEOR;
  logic        mtMBUSY;
  logic        mtMOVR;

  mt_maint_seq #(.RECLEN(RECLEN)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .mtMR      (mtMR),
    .mtmrWRITE (mtmrWRITE),
    .mtMDATA   (mtMDATA),
    .mtMVALID  (mtMVALID),
    .mtMREADY  (mtMREADY),
    .mtMEOR    (mtMEOR),
    .mtMBUSY   (mtMBUSY),
    .mtMOVR    (mtMOVR)
  );

  initial forever #5 clk = ~clk;

  int nCmp = 0;
  int nBad = 0;

  task automatic check(input string name, input int act, input int exp);
    nCmp++;
    if (act !== exp) begin
      nBad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Stimulus state
  logic       mm = 1'b0;
  logic [3:0] mop = '0;
  logic [8:0] mdf = '0;
  logic       mc = 1'b0;
  logic       bpi = 1'b0;
  logic       ready = 1'b0;
  logic       wr = 1'b0;
  int         bpiPer = 6;
  int         bpiCnt = 0;
  logic [9:0] dutLog[$];

  task automatic drive();
    mtMR      = {mdf, bpi, mc, mop, mm};
    mtMREADY  = ready;
    mtmrWRITE = wr;
  endtask

  // One clock: apply inputs, log any transfer happening on the coming edge.
  task automatic step();
    bpi    = (bpiCnt >= bpiPer / 2);
    bpiCnt = (bpiCnt + 1) % bpiPer;
    drive();
    if (rst && mtMVALID && mtMREADY) dutLog.push_back({mtMEOR, mtMDATA});
    @(negedge clk);
    #1;
  endtask

  task automatic runUntil(input int n, input int budget);
    int c = 0;
    while (dutLog.size() < n && c < budget) begin
      step();
      c++;
    end
    if (dutLog.size() < n) check("xferTimeout", dutLog.size(), n);
  endtask

  task automatic waitValid(input int budget);
    int c = 0;
    while (!mtMVALID && c < budget) begin
      step();
      c++;
    end
    check("validTimeout", mtMVALID, 1);
  endtask

  task automatic expectLog(input string name, input int idx, input logic [9:0] exp);
    if (idx < dutLog.size()) check(name, dutLog[idx], exp);
    else                     check(name, dutLog.size(), idx + 1);
  endtask

  // Reference model: record described by mode, seed, index and length.
  function automatic logic [8:0] charAt(input int mode, input logic [8:0] seed, input int idx);
    case (mode)
      3:       return 9'((int'(seed) + idx) % 512);
      4:       return 9'(1 << (idx % 9));
      default: return seed;
    endcase
  endfunction

  logic       mPrev = 1'b0, mBusy = 1'b0, mPres = 1'b0, mDone = 1'b0;
  logic       mRise, mMm;
  int         mOp, mMode = 0, mIdx = 0, mLen = 0;
  logic [8:0] mMdf = '0;
  logic [8:0] eData = '0;
  logic       eEor = 1'b0, eOvr = 1'b0;

  initial forever begin
    @(posedge clk or negedge rst);
    if (!rst) begin
      mPrev = 0; mBusy = 0; mPres = 0; mDone = 0;
      mIdx = 0; mLen = 0; eData = '0; eEor = 0; eOvr = 0;
    end else begin
      mMm   = mtMR[0];
      mOp   = int'(mtMR[4:1]);
      mRise = mtMR[6] && !mPrev;
      mPrev = mtMR[6];
      if (mtmrWRITE) begin
        mBusy = 0; mPres = 0; mDone = 0; eOvr = 0;
      end else begin
        if (mPres && mRise && !mtMREADY) eOvr = 1;
        if (!mBusy) begin
          if (mMm && mOp >= 1 && mOp <= 4) begin
            mBusy = 1; mMode = mOp; mMdf = mtMR[15:7]; mIdx = 0;
            mLen = (mOp == 1) ? 1 : RECLEN;
          end
        end else if (mDone) begin
          if (!mMm) begin mBusy = 0; mDone = 0; end
        end else if (mPres) begin
          if (mtMREADY) mIdx++;
          if (!mMm) begin
            mBusy = 0; mPres = 0;
          end else if (mtMREADY) begin
            mPres = 0;
            if (mIdx == mLen) mDone = 1;
          end
        end else begin
          if (!mMm) mBusy = 0;
          else if (mRise) begin
            mPres = 1;
            eData = charAt(mMode, mMdf, mIdx);
            eEor  = (mIdx + 1 == mLen);
          end
        end
      end
    end
  end

  // Continuous comparison against the model.
  initial forever begin
    @(negedge clk);
    if (rst) begin
      check("valid", mtMVALID, mPres);
      check("busy", mtMBUSY, mBusy);
      check("ovr", mtMOVR, eOvr);
      if (mPres) begin
        check("data", mtMDATA, eData);
        check("eor", mtMEOR, eEor);
      end
    end
  end

  initial begin
    drive();
    #1 rst = 1'b0;
    #2;
    check("rstData", mtMDATA, 0);
    check("rstValid", mtMVALID, 0);
    check("rstEor", mtMEOR, 0);
    check("rstBusy", mtMBUSY, 0);
    check("rstOvr", mtMOVR, 0);
    @(negedge clk); #1;
    rst = 1'b1;
    step();

    // Single character
    mm = 1; mop = 4'd1; mdf = 9'h1A5; ready = 1;
    dutLog.delete();
    runUntil(1, 40);
    expectLog("singleChar", 0, 10'h3A5);
    repeat (10) step();
    check("singleDoneBusy", mtMBUSY, 1);
    check("singleDoneValid", mtMVALID, 0);
    check("singleOneChar", dutLog.size(), 1);
    mm = 0; step();
    check("singleIdle", mtMBUSY, 0);

    // Count with 9-bit wrap
    mm = 1; mop = 4'd3; mdf = 9'h1FE; ready = 1;
    dutLog.delete();
    runUntil(RECLEN, 200);
    expectLog("count0", 0, 10'h1FE);
    expectLog("count1", 1, 10'h1FF);
    expectLog("count2", 2, 10'h000);
    expectLog("count3", 3, 10'h001);
    expectLog("countLast", RECLEN - 1, 10'h207);
    mm = 0; step(); step();

    // Walking one
    mm = 1; mop = 4'd4; mdf = 9'h0F0;
    dutLog.delete();
    runUntil(RECLEN, 200);
    expectLog("walk0", 0, 10'h001);
    expectLog("walk1", 1, 10'h002);
    expectLog("walk8", 8, 10'h100);
    expectLog("walk9", 9, 10'h201);
    mm = 0; step(); step();

    // Repeat with overrun
    mm = 1; mop = 4'd2; mdf = 9'h05A; ready = 0;
    waitValid(40);
    repeat (14) step();
    check("ovrSet", mtMOVR, 1);
    check("ovrHeldValid", mtMVALID, 1);
    check("ovrHeldData", mtMDATA, 9'h05A);
    ready = 1;
    dutLog.delete();
    step();
    expectLog("ovrDeliver", 0, 10'h05A);
    repeat (20) step();
    check("ovrSticky", mtMOVR, 1);
    wr = 1; step(); wr = 0;
    check("ovrClear", mtMOVR, 0);
    check("wrValid", mtMVALID, 0);
    check("wrBusy", mtMBUSY, 0);
    mm = 0; step(); step();

    // Write mid-record, then a fresh record
    mm = 1; mop = 4'd2; mdf = 9'h033; ready = 1;
    dutLog.delete();
    runUntil(2, 60);
    wr = 1; mop = 4'd3; mdf = 9'h100; step(); wr = 0;
    check("midWrValid", mtMVALID, 0);
    check("midWrBusy", mtMBUSY, 0);
    dutLog.delete();
    runUntil(RECLEN, 200);
    expectLog("freshFirst", 0, 10'h100);
    expectLog("freshLast", RECLEN - 1, 10'h309);
    mm = 0; step(); step();

    // Asynchronous reset during SEND
    mm = 1; mop = 4'd2; mdf = 9'h077; ready = 0;
    waitValid(40);
    #2 rst = 1'b0;
    #1;
    check("arstValid", mtMVALID, 0);
    check("arstData", mtMDATA, 0);
    check("arstEor", mtMEOR, 0);
    check("arstBusy", mtMBUSY, 0);
    check("arstOvr", mtMOVR, 0);
    @(negedge clk); #1;
    rst = 1'b1;
    mop = 4'd1; mdf = 9'h1A5; ready = 1;
    dutLog.delete();
    runUntil(1, 40);
    expectLog("postRstSingle", 0, 10'h3A5);
    mm = 0; step(); step();

    // Randomized traffic checked by the model
    mm = 1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) bpiPer = $urandom_range(2, 12);
      if ($urandom_range(0, 99) == 0)  mm = ~mm;
      if ($urandom_range(0, 29) == 0)  mop = 4'($urandom_range(0, 7));
      if ($urandom_range(0, 19) == 0)  mdf = 9'($urandom_range(0, 511));
      if ($urandom_range(0, 9) == 0)   mc = ~mc;
      ready = ($urandom_range(0, 3) != 0);
      wr    = ($urandom_range(0, 149) == 0);
      step();
    end
    wr = 0; mm = 0;
    repeat (4) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule

// File: doc/mt_maint_seq.md
# mt_maint_seq

Maintenance-mode character sequencer for the MT (TM03/TU45-style) tape path. Sits directly downstream of the MT Maintenance Register: decodes the live `mtMR` word (MM, MOP, MDF, BPICLK) and, while maintenance mode is enabled, synthesises tape read characters paced by the BPI clock. Output goes to the formatter's read-data input through a valid/ready handshake, so diagnostics can exercise the read path with no drive attached.

## Interface
Parameters:
- `RECLEN`, 16: characters per generated record (1..4095).

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset; asynchronous, active-low (asserted when 0).
- `mtMR`  in  16  maintenance register: MDF[15:7], BPICLK[6], MC[5], MOP[4:1], MM[0].
- `mtmrWRITE`  in  1  one-cycle pulse; MR written this cycle.
- `mtMDATA`  out  9  generated character.
- `mtMVALID`  out  1  `mtMDATA` valid.
- `mtMREADY`  in  1  consumer accepts character.
- `mtMEOR`  out  1  qualifies `mtMDATA`; last character of record.
- `mtMBUSY`  out  1  sequencer not in IDLE.
- `mtMOVR`  out  1  sticky overrun flag.

## Operation
- MOP decode, latched on IDLE→WAIT:
  - 0 = none.
  - 1 = single: emit MDF once, EOR on it.
  - 2 = repeat: emit MDF RECLEN times.
  - 3 = count: first char MDF, then +1 mod 512 per char, RECLEN chars.
  - 4 = walk: 9'h001 rotated left one bit per char (wraps bit 8→bit 0), RECLEN chars.
  - 5..15 reserved, treated as 0.
- States:
  - IDLE: go to WAIT when MM=1 and MOP in 1..4. Latch MOP and MDF at this transition.
  - WAIT: go to SEND on a BPICLK rising edge. Load the next character and set EOR if the count reaches the record length.
  - SEND: `mtMVALID`=1. On VALID&&READY, decrement count; go to DONE if EOR, else WAIT.
  - DONE: stay while MM=1. Go to IDLE when MM=0.
- BPICLK rising edge: current bit 1 and previous sample 0. The previous-sample register resets to 0.
- Overrun: a BPICLK rising edge while in SEND with VALID&&!READY sets `mtMOVR`. The character is neither dropped nor replaced. The flag clears only on `mtmrWRITE` or reset.
- `mtmrWRITE` in any state forces IDLE next cycle, drops VALID and clears the count. New MR fields are sampled from IDLE the following cycle, because the MR register updates on the write edge.
- MM=0 seen in WAIT or SEND aborts to IDLE next cycle. An in-flight handshake completing on that same cycle counts as a transfer.
- MC is ignored.
- `mtMBUSY` = state≠IDLE.

## Timing
- Reset values: `mtMDATA`=0, `mtMVALID`=0, `mtMEOR`=0, `mtMBUSY`=0, `mtMOVR`=0, state IDLE.
- Latency: BPICLK edge in cycle N puts VALID and data registered at N+1.
- VALID holds, with data/EOR stable, until the READY cycle. No combinational path exists from READY to VALID.
- Back-to-back: after a transfer the sequencer waits for the next BPICLK rising edge. At most one character is emitted per BPI period.
- Count is 12 bits. RECLEN=1 with MOP 2/3/4 behaves like single.
- Simultaneous `mtmrWRITE` and transfer: write wins, the character counts as delivered, and state goes to IDLE.
- Reset mid-record: all outputs drop immediately (asynchronous). Operation resumes from IDLE after rst deasserts.

## Structure
- Package `mt_maint_pkg` holds:
  - MOP enum (MOP_NONE, MOP_SINGLE, MOP_REPEAT, MOP_COUNT, MOP_WALK);
  - MR field bit-position constants;
  - state enum;
  - 9-bit character type.
- One sub-module, `mt_maint_pat`: pattern generator (load/advance/mode → 9-bit char). It keeps datapath arithmetic out of the FSM.

## Test plan
- MM=1, MOP=1, MDF=9'h1A5, READY=1 → one char 9'h1A5 with EOR=1 one cycle after the first BPICLK edge; then DONE, BUSY=1 until MM=0.
- MOP=3, MDF=9'h1FE, RECLEN=4 → chars 1FE, 1FF, 000, 001, with EOR on 001 only, one per BPI period.
- MOP=4, RECLEN=10 → 001, 002, …, 100, 001; EOR on the 10th.
- MOP=2, READY held 0 across two BPICLK edges → VALID and data unchanged, OVR=1. Then READY=1 delivers the held char. OVR stays 1 until `mtmrWRITE`.
- `mtmrWRITE` mid-record (after 2 of 16 chars) → VALID=0 and IDLE next cycle; the new MOP starts a fresh record.
- rst pulled low during SEND → all outputs 0 asynchronously; after release, behaviour is unchanged from a cold start.
